pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, legal range 2..15: mul/div EX occupancy in cycles.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rs1D, rs2D  in  5  decode-stage source registers
- rs1E, rs2E, rdE  in  5  execute-stage source and destination registers
- rdM, rdW  in  5  mem- and wb-stage destination registers
- regwriteM, regwriteW  in  1  register-write flags
- loadE  in  1  load instruction in EX
- pcsrcE  in  1  taken branch or jump in EX
- mdstartE  in  1  mul/div instruction in EX
- memreqM  in  1  data-memory access in MEM
- dmem_ready  in  1  data memory completes access this cycle
- enF, enD, enE, enM, enW  out  1  pipeline-register enables
- clrD, clrE, clrM, clrW  out  1  pipeline-register synchronous clears
- forwardAE, forwardBE  out  2  EX operand select
- md_done  out  1  mul/div result valid this cycle
- stall_cnt  out  16  frozen-fetch cycle counter

Function
REQ-003 SHALL treat pipeline registers as clear-gated-by-enable: clrX SHALL NOT be asserted while enX=0.
REQ-004 SHALL implement FSM states RUN, MEMWAIT, MDBUSY; enable/clear outputs Mealy (state + inputs, same cycle).
REQ-005 Default in RUN, no event: all en=1, all clr=0.
REQ-006 lwstall = loadE && rdE!=0 && (rdE==rs1D || rdE==rs2D); in RUN: enF=enD=0, enE=1, clrE=1.
REQ-007 pcsrcE in RUN: enD=clrD=1, enE=clrE=1, enF=1; overrides lwstall.
REQ-008 RUN with memreqM && !dmem_ready: enF=enD=enE=enM=0, enW=clrW=1; next state MEMWAIT; highest priority, pcsrcE/lwstall/mdstartE ignored that cycle.
REQ-009 MEMWAIT: same outputs as REQ-008 while dmem_ready=0; when dmem_ready=1, all en=1, clr=0 except clrW=0, next state RUN.
REQ-010 RUN with mdstartE (no REQ-008 condition): enF=enD=enE=0, enM=clrM=1; counter loads MD_LAT-2; next state MDBUSY.
REQ-011 MDBUSY, counter>0: outputs as REQ-010, counter decrements.
REQ-012 MDBUSY, counter==0: md_done=1, all en=1, clr=0, next state RUN; mul/div instruction occupies EX exactly MD_LAT cycles including issue cycle.
REQ-013 MDBUSY SHALL ignore mdstartE, memreqM, pcsrcE, loadE.
REQ-014 md_done SHALL be 0 in all other cycles.
REQ-015 forwardAE: 2'b10 if regwriteM && rdM!=0 && rdM==rs1E; else 2'b01 if regwriteW && rdW!=0 && rdW==rs1E; else 2'b00; forwardBE same on rs2E; combinational, state-independent.
REQ-016 stall_cnt SHALL increment on each cycle with enF=0, saturate at 16'hFFFF, never wrap.

Reset
REQ-017 reset SHALL asynchronously force state RUN, mul/div counter 0, stall_cnt 0, md_done 0.
REQ-018 Reset mid-MEMWAIT or mid-MDBUSY SHALL abandon the operation; first post-reset cycle with idle inputs gives all en=1, clr=0.

Verification
REQ-019 loadE=1, rdE=5, rs1D=5 -> enF=enD=0, enE=clrE=1 one cycle; stall_cnt +1.
REQ-020 Same as REQ-019 plus pcsrcE=1 -> enF=1, clrD=clrE=1, stall_cnt unchanged.
REQ-021 memreqM=1, dmem_ready low 3 cycles then high -> enM=0 and clrW=1 for 3 cycles, all en=1 on the 4th, stall_cnt +3.
REQ-022 MD_LAT=4, mdstartE pulse in RUN -> enE=0 for cycles 0-2, md_done=1 and enE=1 in cycle 3, clrM=1 in cycles 0-2.
REQ-023 regwriteM=1, regwriteW=1, rdM=rdW=rs1E=7 -> forwardAE=2'b10; rdM=0 -> 2'b01; rs2E=0 with rdW=0 -> forwardBE=2'b00.
REQ-024 reset asserted in MDBUSY cycle 1 -> md_done never pulses, stall_cnt=0, next cycle all en=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use and branch
// hazards, data-memory wait states, multi-cycle mul/div occupancy and EX forwarding.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic [4:0]  rdM,
    input  logic [4:0]  rdW,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic        loadE,
    input  logic        pcsrcE,
    input  logic        mdstartE,
    input  logic        memreqM,
    input  logic        dmem_ready,
    output logic        enF,
    output logic        enD,
    output logic        enE,
    output logic        enM,
    output logic        enW,
    output logic        clrD,
    output logic        clrE,
    output logic        clrM,
    output logic        clrW,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        md_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEMWAIT, MDBUSY} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  md_cnt_reg, md_cnt_next;
    logic [15:0] stall_cnt_reg;
    logic        lwstall;
    logic        memstall;

    assign lwstall  = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    assign memstall = memreqM && !dmem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= RUN;
            md_cnt_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            md_cnt_reg <= md_cnt_next;
        end
    end

    // Clears are only ever raised alongside their stage enable.
    always_comb begin
        state_next  = state_reg;
        md_cnt_next = md_cnt_reg;
        enF = 1'b1; enD = 1'b1; enE = 1'b1; enM = 1'b1; enW = 1'b1;
        clrD = 1'b0; clrE = 1'b0; clrM = 1'b0; clrW = 1'b0;
        md_done = 1'b0;
        case (state_reg)
            RUN: begin
                if (memstall) begin
                    enF = 1'b0; enD = 1'b0; enE = 1'b0; enM = 1'b0;
                    clrW = 1'b1;
                    state_next = MEMWAIT;
                end else if (mdstartE) begin
                    enF = 1'b0; enD = 1'b0; enE = 1'b0;
                    clrM = 1'b1;
                    md_cnt_next = 4'(MD_LAT - 2);
                    state_next  = MDBUSY;
                end else if (pcsrcE) begin
                    clrD = 1'b1;
                    clrE = 1'b1;
                end else if (lwstall) begin
                    enF = 1'b0; enD = 1'b0;
                    clrE = 1'b1;
                end
            end
            MEMWAIT: begin
                if (!dmem_ready) begin
                    enF = 1'b0; enD = 1'b0; enE = 1'b0; enM = 1'b0;
                    clrW = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            MDBUSY: begin
                // Count reaches zero on the final EX cycle of the mul/div.
                if (md_cnt_reg != 4'd0) begin
                    enF = 1'b0; enD = 1'b0; enE = 1'b0;
                    clrM = 1'b1;
                    md_cnt_next = md_cnt_reg - 4'd1;
                end else begin
                    md_done    = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_reg <= 16'd0;
        else if (!enF && (stall_cnt_reg != 16'hFFFF))
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end

    assign stall_cnt = stall_cnt_reg;

    // Operand forwarding: MEM result takes precedence over WB result.
    logic [4:0] rs_e  [2];
    logic [1:0] fwd_e [2];

    assign rs_e[0]   = rs1E;
    assign rs_e[1]   = rs2E;
    assign forwardAE = fwd_e[0];
    assign forwardBE = fwd_e[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_e[gi] = 2'b00;
                if (regwriteM && (rdM != 5'd0) && (rdM == rs_e[gi]))
                    fwd_e[gi] = 2'b10;
                else if (regwriteW && (rdW != 5'd0) && (rdW == rs_e[gi]))
                    fwd_e[gi] = 2'b01;
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs driven on the falling edge,
// outputs checked 1 time unit later, state advancing on the rising edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regwriteM, regwriteW, loadE, pcsrcE, mdstartE, memreqM, dmem_ready;
    logic        enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW;
    logic [1:0]  forwardAE, forwardBE;
    logic        md_done;
    logic [15:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // {enF,enD,enE,enM,enW,clrD,clrE,clrM,clrW}
    logic [8:0] ctl;
    assign ctl = {enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW};

    localparam logic [8:0] CTL_IDLE   = 9'b11111_0000;
    localparam logic [8:0] CTL_LW     = 9'b00111_0100;
    localparam logic [8:0] CTL_BR     = 9'b11111_1100;
    localparam logic [8:0] CTL_MEM    = 9'b00001_0001;
    localparam logic [8:0] CTL_MD     = 9'b00011_0010;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .loadE(loadE), .pcsrcE(pcsrcE), .mdstartE(mdstartE), .memreqM(memreqM),
        .dmem_ready(dmem_ready),
        .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
        .clrD(clrD), .clrE(clrE), .clrM(clrM), .clrW(clrW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .md_done(md_done), .stall_cnt(stall_cnt)
    );

    task automatic idle_inputs();
        rs1D = 5'd1; rs2D = 5'd2; rs1E = 5'd3; rs2E = 5'd4; rdE = 5'd6;
        rdM = 5'd8; rdW = 5'd9; regwriteM = 1'b0; regwriteW = 1'b0;
        loadE = 1'b0; pcsrcE = 1'b0; mdstartE = 1'b0; memreqM = 1'b0;
        dmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        tests_run++;
        if (stall_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        tests_run++;
        if (md_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_md_done: got %b expected 0", md_done);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (ctl !== CTL_IDLE) begin
            tests_failed++;
            $display("FAIL reset_idle_ctl: got %b expected %b", ctl, CTL_IDLE);
        end
        $display("[TB] reset: ctl=%b stall_cnt=%0d", ctl, stall_cnt);
    endtask

    task automatic test_lwstall();
        logic [15:0] base;
        @(negedge clk);
        idle_inputs();
        base = stall_cnt;
        loadE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
        #1;
        tests_run++;
        if (ctl !== CTL_LW) begin
            tests_failed++;
            $display("FAIL lwstall_ctl: got %b expected %b", ctl, CTL_LW);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (stall_cnt !== base + 16'd1) begin
            tests_failed++;
            $display("FAIL lwstall_cnt: got %0d expected %0d", stall_cnt, base + 16'd1);
        end
        // rdE == x0 never causes a load-use stall
        loadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
        #1;
        tests_run++;
        if (ctl !== CTL_IDLE) begin
            tests_failed++;
            $display("FAIL lwstall_x0: got %b expected %b", ctl, CTL_IDLE);
        end
        // match on rs2D
        rdE = 5'd12; rs2D = 5'd12;
        #1;
        tests_run++;
        if (ctl !== CTL_LW) begin
            tests_failed++;
            $display("FAIL lwstall_rs2: got %b expected %b", ctl, CTL_LW);
        end
        $display("[TB] lwstall: ctl=%b stall_cnt=%0d", ctl, stall_cnt);
    endtask

    task automatic test_branch();
        logic [15:0] base;
        @(negedge clk);
        idle_inputs();
        base = stall_cnt;
        loadE = 1'b1; rdE = 5'd5; rs1D = 5'd5; pcsrcE = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_BR) begin
            tests_failed++;
            $display("FAIL branch_ctl: got %b expected %b", ctl, CTL_BR);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (stall_cnt !== base) begin
            tests_failed++;
            $display("FAIL branch_cnt: got %0d expected %0d", stall_cnt, base);
        end
        $display("[TB] branch: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_memwait();
        logic [15:0] base;
        @(negedge clk);
        idle_inputs();
        base = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            idle_inputs();
            memreqM = 1'b1; dmem_ready = 1'b0;
            if (i == 0) pcsrcE = 1'b1;
            if (i == 1) mdstartE = 1'b1;
            #1;
            tests_run++;
            if (ctl !== CTL_MEM) begin
                tests_failed++;
                $display("FAIL memwait_ctl%0d: got %b expected %b", i, ctl, CTL_MEM);
            end
        end
        @(negedge clk);
        idle_inputs();
        memreqM = 1'b1; dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_IDLE) begin
            tests_failed++;
            $display("FAIL memwait_release: got %b expected %b", ctl, CTL_IDLE);
        end
        tests_run++;
        if (stall_cnt !== base + 16'd3) begin
            tests_failed++;
            $display("FAIL memwait_cnt: got %0d expected %0d", stall_cnt, base + 16'd3);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (ctl !== CTL_IDLE) begin
            tests_failed++;
            $display("FAIL memwait_after: got %b expected %b", ctl, CTL_IDLE);
        end
        $display("[TB] memwait: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_muldiv();
        logic [15:0] base;
        @(negedge clk);
        idle_inputs();
        base = stall_cnt;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            idle_inputs();
            if (c == 0) mdstartE = 1'b1;
            if (c == 1) begin
                mdstartE = 1'b1; memreqM = 1'b1; dmem_ready = 1'b0; pcsrcE = 1'b1;
            end
            if (c == 2) begin
                loadE = 1'b1; rdE = 5'd1;
            end
            #1;
            tests_run++;
            if (ctl !== ((c < 3) ? CTL_MD : CTL_IDLE)) begin
                tests_failed++;
                $display("FAIL muldiv_ctl%0d: got %b expected %b", c, ctl,
                         (c < 3) ? CTL_MD : CTL_IDLE);
            end
            tests_run++;
            if (md_done !== (c == 3)) begin
                tests_failed++;
                $display("FAIL muldiv_done%0d: got %b expected %b", c, md_done, c == 3);
            end
        end
        tests_run++;
        if (stall_cnt !== base + 16'd3) begin
            tests_failed++;
            $display("FAIL muldiv_cnt: got %0d expected %0d", stall_cnt, base + 16'd3);
        end
        $display("[TB] muldiv: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_forward();
        @(negedge clk);
        idle_inputs();
        regwriteM = 1'b1; regwriteW = 1'b1; rdM = 5'd7; rdW = 5'd7; rs1E = 5'd7;
        #1;
        tests_run++;
        if (forwardAE !== 2'b10) begin
            tests_failed++;
            $display("FAIL fwdA_mem: got %b expected 10", forwardAE);
        end
        rdM = 5'd0;
        #1;
        tests_run++;
        if (forwardAE !== 2'b01) begin
            tests_failed++;
            $display("FAIL fwdA_wb: got %b expected 01", forwardAE);
        end
        rs2E = 5'd0; rdW = 5'd0;
        #1;
        tests_run++;
        if (forwardBE !== 2'b00) begin
            tests_failed++;
            $display("FAIL fwdB_x0: got %b expected 00", forwardBE);
        end
        regwriteM = 1'b0; rdM = 5'd11; rdW = 5'd11; rs2E = 5'd11;
        #1;
        tests_run++;
        if (forwardBE !== 2'b01) begin
            tests_failed++;
            $display("FAIL fwdB_wb: got %b expected 01", forwardBE);
        end
        regwriteM = 1'b1;
        #1;
        tests_run++;
        if (forwardBE !== 2'b10) begin
            tests_failed++;
            $display("FAIL fwdB_mem: got %b expected 10", forwardBE);
        end
        $display("[TB] forward: A=%b B=%b", forwardAE, forwardBE);
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        idle_inputs();
        mdstartE = 1'b1;
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        tests_run++;
        if (stall_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_cnt: got %0d expected 0", stall_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (ctl !== CTL_IDLE) begin
            tests_failed++;
            $display("FAIL rstmid_ctl: got %b expected %b", ctl, CTL_IDLE);
        end
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (md_done) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL rstmid_done: got %0d pulses expected 0", done_seen);
        end
        $display("[TB] reset_mid: ctl=%b stall_cnt=%0d", ctl, stall_cnt);
    endtask

    task automatic test_saturate();
        @(negedge clk);
        idle_inputs();
        loadE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
        repeat (65540) @(negedge clk);
        #1;
        tests_run++;
        if (stall_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL saturate: got %h expected ffff", stall_cnt);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (stall_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL saturate_hold: got %h expected ffff", stall_cnt);
        end
        idle_inputs();
        $display("[TB] saturate: stall_cnt=%h", stall_cnt);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_lwstall();
        test_branch();
        test_memwait();
        test_muldiv();
        test_forward();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
